inst_mem_sync: RTL

Parametrised synchronous instruction memory that replaces the combinational instruction ROM for the pipelined datapath. Fetch uses a valid/ready request/response handshake with one-cycle read latency. A write port loads the program at run time. A reset-time clear state machine zeroes the array so that unloaded words read as nop. Misaligned and out-of-range fetches are flagged and return nop instead of aliasing.

---
 rtl/inst_mem_sync.sv | 122 ++++++++++++
 1 files changed

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory with a one-entry response register.
// After reset a clear sweep zeroes the array so that words never loaded read as nop.
module inst_mem_sync #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_inst,
    output logic [1:0]        rsp_fault,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              init_busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX   = $clog2(DEPTH);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX-1:0]    cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic           req_mis;
    logic           req_oor;
    logic           wr_oor;
    logic           accept;
    logic [IDX-1:0] req_idx;
    logic [IDX-1:0] wr_idx;

    assign req_idx = req_addr[OFS+IDX-1:OFS];
    assign wr_idx  = wr_addr[OFS+IDX-1:OFS];

    generate
        if (OFS > 0) begin : g_ofs
            logic unused_wr_ofs;
            assign req_mis       = |req_addr[OFS-1:0];
            assign unused_wr_ofs = ^wr_addr[OFS-1:0];
        end else begin : g_no_ofs
            assign req_mis = 1'b0;
        end

        if (ADDR_W > OFS + IDX) begin : g_hi
            assign req_oor = |req_addr[ADDR_W-1:OFS+IDX];
            assign wr_oor  = |wr_addr[ADDR_W-1:OFS+IDX];
        end else begin : g_no_hi
            assign req_oor = 1'b0;
            assign wr_oor  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && cnt == IDX'(DEPTH - 1)) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        init_busy = (state == S_INIT);
        req_ready = (state == S_RUN) && (!rsp_valid || rsp_ready);
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_INIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Reset itself leaves the array alone; only the sweep or a load write it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_INIT) begin
                mem[cnt] <= '0;
            end else if (wr_en && !wr_oor) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

    // Non-blocking read gives read-first behaviour against a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_inst  <= '0;
            rsp_fault <= 2'b00;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= {req_oor, req_mis};
            rsp_inst  <= (req_mis || req_oor) ? '0 : mem[req_idx];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
